// File: rtl/pair_mac_pkg.sv
// rtl/pair_mac_pkg.sv - shared types for the pair multiply-accumulate block
package pair_mac_pkg;

    localparam int PROD_W = 18;

    // sel0 = x, sel1 = y
    typedef struct packed {
        logic signed [8:0] sel0;
        logic signed [8:0] sel1;
    } product0;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        OUTPUT = 2'd2
    } state_e;

endpackage

// File: rtl/pair_mult.sv
// rtl/pair_mult.sv - registered 9x9 signed multiplier (stage 1)
module pair_mult
    import pair_mac_pkg::*;
(
    input  logic                     system1000,
    input  logic                     system1000_rstn,
    input  logic                     in_fire,
    input  product0                  in_pair,
    output logic signed [PROD_W-1:0] prod,
    output logic                     prod_vld
);

    logic signed [PROD_W-1:0] prod_d, prod_q;
    logic                     prod_vld_d, prod_vld_q;

    always_comb begin
        prod_d     = prod_q;
        prod_vld_d = in_fire;
        if (in_fire) begin
            prod_d = PROD_W'(in_pair.sel0) * PROD_W'(in_pair.sel1);
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
        end else begin
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
        end
    end

    assign prod     = prod_q;
    assign prod_vld = prod_vld_q;

endmodule

// File: rtl/pair_mac.sv
// rtl/pair_mac.sv - sums x*y over LEN accepted pairs, one result per frame
module pair_mac
    import pair_mac_pkg::*;
#(
    parameter  int LEN   = 4,
    localparam int ACC_W = PROD_W + $clog2(LEN)
) (
    input  logic                    system1000,
    input  logic                    system1000_rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  product0                 in_pair,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc
);

    localparam int CNT_W = $clog2(LEN);

    state_e                   state_d, state_q;
    logic [CNT_W-1:0]         cnt_d, cnt_q;
    logic signed [ACC_W-1:0]  acc_d, acc_q;
    logic                     in_ready_d, in_ready_q;
    logic                     out_valid_d, out_valid_q;
    logic signed [PROD_W-1:0] prod;
    logic                     prod_vld;
    logic                     in_fire, out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    pair_mult u_mult (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .in_fire         (in_fire),
        .in_pair         (in_pair),
        .prod            (prod),
        .prod_vld        (prod_vld)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (prod_vld) begin
            acc_d = acc_q + ACC_W'(prod);
        end
        case (state_q)
            ACCUM: begin
                if (in_fire) begin
                    if (cnt_q == CNT_W'(LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            // the last product is still in stage 1 and lands in acc here
            DRAIN:   state_d = OUTPUT;
            OUTPUT: begin
                if (out_fire) begin
                    acc_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == OUTPUT);
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;

endmodule
